// File: rtl/hyperbus_arbiter.sv
// Two-port arbiter in front of a single HyperBus controller core.
// Define HYPERBUS_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module hyperbus_arbiter #(
    parameter int ADR_WIDTH  = 32,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  p0_rrq,
    input  logic                  p0_wrq,
    input  logic [ADR_WIDTH-1:0]  p0_adr_i,
    input  logic [DATA_WIDTH-1:0] p0_dat_i,
    output logic [DATA_WIDTH-1:0] p0_dat_o,
    output logic                  p0_ack,
    input  logic                  p1_rrq,
    input  logic                  p1_wrq,
    input  logic [ADR_WIDTH-1:0]  p1_adr_i,
    input  logic [DATA_WIDTH-1:0] p1_dat_i,
    output logic [DATA_WIDTH-1:0] p1_dat_o,
    output logic                  p1_ack,
    output logic [1:0]            gnt,
    output logic [ADR_WIDTH-1:0]  hbus_adr_o,
    output logic [DATA_WIDTH-1:0] hbus_dat_o,
    input  logic [DATA_WIDTH-1:0] hbus_dat_i,
    output logic                  hbus_rrq,
    output logic                  hbus_wrq,
    input  logic                  hbus_ready,
    input  logic                  hbus_valid,
    input  logic                  hbus_busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [1:0]            gnt_q, gnt_d;
    logic                  owner_q, owner_d;
    logic                  rd_q, rd_d;
    logic [ADR_WIDTH-1:0]  adr_lat_q, adr_lat_d;
    logic [DATA_WIDTH-1:0] dat_lat_q, dat_lat_d;
    logic [ADR_WIDTH-1:0]  hadr_q, hadr_d;
    logic [DATA_WIDTH-1:0] hdat_q, hdat_d;
    logic                  hrrq_q, hrrq_d;
    logic                  hwrq_q, hwrq_d;
    logic                  seen_busy_q, seen_busy_d;
    logic [1:0]            ack_q, ack_d;
    logic [DATA_WIDTH-1:0] dat0_q, dat0_d;
    logic [DATA_WIDTH-1:0] dat1_q, dat1_d;
`ifdef HYPERBUS_ARB_RR_EN
    logic                  last_q, last_d;
`endif

    logic req0, req1, win1, done;

    always_comb begin
        req0 = p0_rrq | p0_wrq;
        req1 = p1_rrq | p1_wrq;
`ifdef HYPERBUS_ARB_RR_EN
        // last_q=1 means port 1 was served last, so port 0 wins a tie.
        win1 = req1 & (~req0 | ~last_q);
        last_d = last_q;
`else
        win1 = req1 & ~req0;
`endif
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        rd_d        = rd_q;
        adr_lat_d   = adr_lat_q;
        dat_lat_d   = dat_lat_q;
        hadr_d      = hadr_q;
        hdat_d      = hdat_q;
        hrrq_d      = 1'b0;
        hwrq_d      = 1'b0;
        seen_busy_d = seen_busy_q;
        ack_d       = 2'b00;
        dat0_d      = dat0_q;
        dat1_d      = dat1_q;
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // No grant while an ack is out: the requester has not yet had a chance to drop its request.
                if (hbus_ready && (req0 || req1) && (ack_q == 2'b00)) begin
                    owner_d   = win1;
                    gnt_d     = win1 ? 2'b10 : 2'b01;
                    rd_d      = win1 ? p1_rrq : p0_rrq;
                    adr_lat_d = win1 ? p1_adr_i : p0_adr_i;
                    dat_lat_d = win1 ? p1_dat_i : p0_dat_i;
                    state_d   = ST_ISSUE;
`ifdef HYPERBUS_ARB_RR_EN
                    last_d    = win1;
`endif
                end
            end
            ST_ISSUE: begin
                hadr_d      = adr_lat_q;
                hdat_d      = dat_lat_q;
                hrrq_d      = rd_q;
                hwrq_d      = ~rd_q;
                seen_busy_d = 1'b0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                seen_busy_d = seen_busy_q | hbus_busy;
                if (rd_q && hbus_valid) begin
                    if (owner_q) dat1_d = hbus_dat_i;
                    else         dat0_d = hbus_dat_i;
                    done = 1'b1;
                end else if (!rd_q && seen_busy_q && !hbus_busy) begin
                    done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (done) begin
            ack_d[owner_q] = 1'b1;
            gnt_d          = 2'b00;
            state_d        = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 2'b00;
            owner_q     <= 1'b0;
            rd_q        <= 1'b0;
            adr_lat_q   <= '0;
            dat_lat_q   <= '0;
            hadr_q      <= '0;
            hdat_q      <= '0;
            hrrq_q      <= 1'b0;
            hwrq_q      <= 1'b0;
            seen_busy_q <= 1'b0;
            ack_q       <= 2'b00;
            dat0_q      <= '0;
            dat1_q      <= '0;
`ifdef HYPERBUS_ARB_RR_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            rd_q        <= rd_d;
            adr_lat_q   <= adr_lat_d;
            dat_lat_q   <= dat_lat_d;
            hadr_q      <= hadr_d;
            hdat_q      <= hdat_d;
            hrrq_q      <= hrrq_d;
            hwrq_q      <= hwrq_d;
            seen_busy_q <= seen_busy_d;
            ack_q       <= ack_d;
            dat0_q      <= dat0_d;
            dat1_q      <= dat1_d;
`ifdef HYPERBUS_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign gnt        = gnt_q;
    assign hbus_adr_o = hadr_q;
    assign hbus_dat_o = hdat_q;
    assign hbus_rrq   = hrrq_q;
    assign hbus_wrq   = hwrq_q;
    assign p0_ack     = ack_q[0];
    assign p1_ack     = ack_q[1];
    assign p0_dat_o   = dat0_q;
    assign p1_dat_o   = dat1_q;

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Bench for hyperbus_arbiter: scripted core responder, transaction-level reference model,
// per-cycle output comparison plus hand-computed expectations for each directed scenario.
module tb_hyperbus_arbiter;

    localparam int AW = 32;
    localparam int DW = 16;
`ifdef HYPERBUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn = 1'b0;
    logic          p0_rrq = 1'b0, p0_wrq = 1'b0, p1_rrq = 1'b0, p1_wrq = 1'b0;
    logic [AW-1:0] p0_adr_i = '0, p1_adr_i = '0;
    logic [DW-1:0] p0_dat_i = '0, p1_dat_i = '0;
    logic [DW-1:0] p0_dat_o, p1_dat_o;
    logic          p0_ack, p1_ack;
    logic [1:0]    gnt;
    logic [AW-1:0] hbus_adr_o;
    logic [DW-1:0] hbus_dat_o;
    logic [DW-1:0] hbus_dat_i = '0;
    logic          hbus_rrq, hbus_wrq;
    logic          hbus_ready = 1'b0, hbus_valid = 1'b0, hbus_busy = 1'b0;

    hyperbus_arbiter #(.ADR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rstn(rstn),
        .p0_rrq(p0_rrq), .p0_wrq(p0_wrq), .p0_adr_i(p0_adr_i), .p0_dat_i(p0_dat_i),
        .p0_dat_o(p0_dat_o), .p0_ack(p0_ack),
        .p1_rrq(p1_rrq), .p1_wrq(p1_wrq), .p1_adr_i(p1_adr_i), .p1_dat_i(p1_dat_i),
        .p1_dat_o(p1_dat_o), .p1_ack(p1_ack),
        .gnt(gnt), .hbus_adr_o(hbus_adr_o), .hbus_dat_o(hbus_dat_o), .hbus_dat_i(hbus_dat_i),
        .hbus_rrq(hbus_rrq), .hbus_wrq(hbus_wrq), .hbus_ready(hbus_ready),
        .hbus_valid(hbus_valid), .hbus_busy(hbus_busy)
    );

    // ---------------- scripted core ----------------
    bit            ready_en = 1'b1;
    int            rd_lat = 2, wr_len = 4;
    logic [DW-1:0] rd_data = '0;
    int            spur_cnt = 0, spur_done = 0;
    int            core_mode = 0, core_cnt = 0;

    always @(posedge clk) begin
        #1;
        hbus_valid = 1'b0;
        if (!rstn) begin
            core_mode = 0;
            core_cnt  = 0;
        end else if (hbus_rrq) begin
            core_mode = 1;
            core_cnt  = rd_lat;
        end else if (hbus_wrq) begin
            core_mode = 2;
            core_cnt  = wr_len;
        end else if (core_mode != 0) begin
            if (core_cnt == 0) begin
                if (core_mode == 1) begin
                    hbus_valid = 1'b1;
                    hbus_dat_i = rd_data;
                end
                core_mode = 0;
            end else begin
                core_cnt--;
            end
        end
        if (spur_cnt != spur_done) begin
            spur_done  = spur_cnt;
            hbus_valid = 1'b1;
            hbus_dat_i = 16'hDEAD;
        end
        hbus_busy  = (core_mode != 0);
        hbus_ready = ready_en && (core_mode == 0);
    end

    // ---------------- reference model ----------------
    // One transaction at a time: m_age counts clock edges since the grant;
    // the core request pulse is visible one edge after the grant.
    bit            m_act = 1'b0;
    int            m_owner = 0;
    bit            m_rd = 1'b0;
    logic [AW-1:0] m_adr_l = '0, m_hadr = '0;
    logic [DW-1:0] m_dat_l = '0, m_hdat = '0;
    int            m_age = 0;
    bit            m_seen = 1'b0;
    logic [1:0]    m_ack = '0;
    logic [DW-1:0] m_do0 = '0, m_do1 = '0;
    int            m_last = 1;
    int            m_grants[$];

    always @(posedge clk or negedge rstn) begin : model
        logic [1:0] nack;
        logic       r0, r1;
        int         w;
        if (!rstn) begin
            m_act = 1'b0; m_owner = 0; m_rd = 1'b0; m_age = 0; m_seen = 1'b0;
            m_adr_l = '0; m_dat_l = '0; m_hadr = '0; m_hdat = '0;
            m_ack = '0; m_do0 = '0; m_do1 = '0; m_last = 1;
        end else begin
            nack = 2'b00;
            r0 = p0_rrq | p0_wrq;
            r1 = p1_rrq | p1_wrq;
            if (!m_act) begin
                if (hbus_ready && (r0 || r1) && m_ack == 2'b00) begin
                    if (r0 && r1) w = RR ? ((m_last == 0) ? 1 : 0) : 0;
                    else          w = r1 ? 1 : 0;
                    m_act   = 1'b1;
                    m_age   = 0;
                    m_owner = w;
                    m_rd    = (w == 1) ? p1_rrq : p0_rrq;
                    m_adr_l = (w == 1) ? p1_adr_i : p0_adr_i;
                    m_dat_l = (w == 1) ? p1_dat_i : p0_dat_i;
                    m_last  = w;
                    m_grants.push_back(w);
                end
            end else if (m_age == 0) begin
                m_age  = 1;
                m_hadr = m_adr_l;
                m_hdat = m_dat_l;
                m_seen = 1'b0;
            end else begin
                m_age++;
                if (m_rd && hbus_valid) begin
                    if (m_owner == 1) m_do1 = hbus_dat_i; else m_do0 = hbus_dat_i;
                    nack[m_owner] = 1'b1;
                    m_act = 1'b0;
                end else if (!m_rd && m_seen && !hbus_busy) begin
                    nack[m_owner] = 1'b1;
                    m_act = 1'b0;
                end
                m_seen = m_seen | hbus_busy;
            end
            m_ack = nack;
        end
    end

    // ---------------- DUT monitor ----------------
    int            n_rrq = 0, n_wrq = 0, n_ack0 = 0, n_ack1 = 0, n_gnt_cyc = 0;
    int            mcyc = 0, fall_cyc = 0, ack1_cyc = 0;
    logic [AW-1:0] pulse_adr = '0;
    logic [DW-1:0] pulse_dat = '0;
    int            pulse_log[$], grant_log[$];
    logic [1:0]    prev_gnt = 2'b00;
    logic          prev_busy = 1'b0;

    always @(negedge clk) begin
        mcyc++;
        if (hbus_rrq) begin n_rrq++; pulse_adr = hbus_adr_o; pulse_log.push_back(0); end
        if (hbus_wrq) begin n_wrq++; pulse_adr = hbus_adr_o; pulse_dat = hbus_dat_o; pulse_log.push_back(1); end
        if (p0_ack) n_ack0++;
        if (p1_ack) begin n_ack1++; ack1_cyc = mcyc; end
        if (gnt != 2'b00) n_gnt_cyc++;
        if (gnt != 2'b00 && prev_gnt == 2'b00) grant_log.push_back((gnt == 2'b10) ? 1 : 0);
        if (prev_busy && !hbus_busy) fall_cyc = mcyc;
        prev_gnt  = gnt;
        prev_busy = hbus_busy;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_cycle();
        logic [1:0] eg;
        eg = m_act ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
        chk("gnt", {30'd0, gnt}, {30'd0, eg});
        chk("hbus_rrq", {31'd0, hbus_rrq}, {31'd0, m_act && m_age == 1 && m_rd});
        chk("hbus_wrq", {31'd0, hbus_wrq}, {31'd0, m_act && m_age == 1 && !m_rd});
        chk("hbus_adr_o", hbus_adr_o, m_hadr);
        chk("hbus_dat_o", {16'd0, hbus_dat_o}, {16'd0, m_hdat});
        chk("p0_ack", {31'd0, p0_ack}, {31'd0, m_ack[0]});
        chk("p1_ack", {31'd0, p1_ack}, {31'd0, m_ack[1]});
        chk("p0_dat_o", {16'd0, p0_dat_o}, {16'd0, m_do0});
        chk("p1_dat_o", {16'd0, p1_dat_o}, {16'd0, m_do1});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int port, input int bound);
        bit got;
        got = 1'b0;
        for (int k = 0; k < bound && !got; k++) begin
            step();
            if ((port == 0) ? p0_ack : p1_ack) got = 1'b1;
        end
        chk($sformatf("ack_seen_p%0d", port), {31'd0, got}, 32'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int bound);
        bit got;
        got = 1'b0;
        for (int k = 0; k < bound && !got; k++) begin
            step();
            if (gnt != 2'b00) got = 1'b1;
        end
        chk("gnt_seen", {31'd0, got}, 32'd1);
    endtask

    initial begin
        int a0, a1, r, wq, gi0, pi0, gc, n;
        bit fin;
        int exp4[4];

        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        // reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_p0_dat_o", {16'd0, p0_dat_o}, 32'd0);
        chk("rst_hbus_adr_o", hbus_adr_o, 32'd0);
        step();
        rstn = 1'b1;
        repeat (2) step();

        // p0 read at 0x10 returns 0xBEEF
        r = n_rrq; a0 = n_ack0; a1 = n_ack1;
        rd_lat = 2; rd_data = 16'hBEEF;
        p0_adr_i = 32'h0000_0010; p0_rrq = 1'b1;
        wait_ack(0, 100);
        p0_rrq = 1'b0;
        $display("txn p0 read adr=0x10 dat_o=0x%0h", p0_dat_o);
        chk("rd_rrq_pulses", n_rrq - r, 32'd1);
        chk("rd_pulse_adr", pulse_adr, 32'h10);
        chk("rd_p0_dat_o", {16'd0, p0_dat_o}, 32'hBEEF);
        chk("rd_p0_acks", n_ack0 - a0, 32'd1);
        chk("rd_p1_acks", n_ack1 - a1, 32'd0);
        chk("rd_p1_dat_o", {16'd0, p1_dat_o}, 32'd0);
        repeat (2) step();

        // p1 write 0x1234 at 0x20, busy for 5 cycles, request dropped right after grant
        r = n_rrq; wq = n_wrq; a1 = n_ack1;
        wr_len = 4;
        p1_adr_i = 32'h20; p1_dat_i = 16'h1234; p1_wrq = 1'b1;
        wait_gnt(50);
        p1_wrq = 1'b0;
        wait_ack(1, 100);
        $display("txn p1 write adr=0x20 dat=0x%0h", pulse_dat);
        chk("wr_wrq_pulses", n_wrq - wq, 32'd1);
        chk("wr_rrq_pulses", n_rrq - r, 32'd0);
        chk("wr_pulse_dat", {16'd0, pulse_dat}, 32'h1234);
        chk("wr_pulse_adr", pulse_adr, 32'h20);
        chk("wr_p1_acks", n_ack1 - a1, 32'd1);
        chk("wr_ack_after_busy", ack1_cyc - fall_cyc, 32'd1);
        step();
        chk("wr_gnt_idle", {30'd0, gnt}, 32'd0);

        // spurious valid with nobody granted
        spur_cnt++;
        repeat (3) step();
        $display("txn spurious valid p0_dat_o=0x%0h", p0_dat_o);
        chk("spur_p0_dat_o", {16'd0, p0_dat_o}, 32'hBEEF);
        chk("spur_p1_dat_o", {16'd0, p1_dat_o}, 32'd0);

        // both ports read back-to-back, four transactions
        gi0 = grant_log.size(); pi0 = m_grants.size();
        rd_data = 16'h1111;
        p0_adr_i = 32'h30; p1_adr_i = 32'h34;
        p0_rrq = 1'b1; p1_rrq = 1'b1;
        n = 0; fin = 1'b0;
        for (int k = 0; k < 400 && !fin; k++) begin
            step();
            if (p0_ack || p1_ack) n++;
            if (n == 4) fin = 1'b1;
        end
        p0_rrq = 1'b0; p1_rrq = 1'b0;
        chk("arb_four_acks", {31'd0, fin}, 32'd1);
        if (RR) exp4 = '{0, 1, 0, 1};
        else    exp4 = '{0, 0, 0, 0};
        for (int k = 0; k < 4; k++) begin
            $display("txn arb grant %0d -> port %0d", k, (gi0 + k < grant_log.size()) ? grant_log[gi0 + k] : -1);
            chk($sformatf("arb_grant%0d", k), (gi0 + k < grant_log.size()) ? grant_log[gi0 + k] : -1, exp4[k]);
            chk($sformatf("model_grant%0d", k), (pi0 + k < m_grants.size()) ? m_grants[pi0 + k] : -1, exp4[k]);
        end
        repeat (2) step();
        chk("arb_p1_dat_o", {16'd0, p1_dat_o}, RR ? 32'h1111 : 32'd0);

        // p0 read and write together: read first, then write
        pi0 = pulse_log.size();
        rd_data = 16'h2222;
        p0_adr_i = 32'h40; p0_dat_i = 16'hCAFE;
        p0_rrq = 1'b1; p0_wrq = 1'b1;
        wait_ack(0, 100);
        p0_rrq = 1'b0;
        wait_ack(0, 100);
        p0_wrq = 1'b0;
        $display("txn p0 rd+wr pulses=%0d", pulse_log.size() - pi0);
        chk("rw_pulse_count", pulse_log.size() - pi0, 32'd2);
        chk("rw_first_read", (pulse_log.size() > pi0) ? pulse_log[pi0] : -1, 32'd0);
        chk("rw_then_write", (pulse_log.size() > pi0 + 1) ? pulse_log[pi0 + 1] : -1, 32'd1);
        chk("rw_p0_dat_o", {16'd0, p0_dat_o}, 32'h2222);
        chk("rw_wr_dat", {16'd0, pulse_dat}, 32'hCAFE);
        repeat (2) step();

        // core not ready: request must wait
        ready_en = 1'b0;
        repeat (2) step();
        gc = n_gnt_cyc; r = n_rrq; wq = n_wrq;
        rd_data = 16'h3333;
        p1_adr_i = 32'h50; p1_rrq = 1'b1;
        repeat (6) step();
        chk("nrdy_gnt_cycles", n_gnt_cyc - gc, 32'd0);
        chk("nrdy_pulses", (n_rrq - r) + (n_wrq - wq), 32'd0);
        ready_en = 1'b1;
        wait_ack(1, 100);
        p1_rrq = 1'b0;
        $display("txn p1 read after ready dat_o=0x%0h", p1_dat_o);
        chk("nrdy_p1_dat_o", {16'd0, p1_dat_o}, 32'h3333);
        repeat (2) step();

        // reset in the middle of a read
        rd_lat = 10; rd_data = 16'h5A5A;
        p0_adr_i = 32'h60; p0_rrq = 1'b1;
        wait_gnt(50);
        repeat (3) step();
        a0 = n_ack0;
        rstn = 1'b0;
        @(negedge clk);
        chk("mrst_gnt", {30'd0, gnt}, 32'd0);
        chk("mrst_p0_ack", {31'd0, p0_ack}, 32'd0);
        repeat (2) step();
        rstn = 1'b1;
        wait_ack(0, 100);
        p0_rrq = 1'b0;
        $display("txn p0 read after reset dat_o=0x%0h", p0_dat_o);
        chk("mrst_p0_dat_o", {16'd0, p0_dat_o}, 32'h5A5A);
        chk("mrst_acks", n_ack0 - a0, 32'd1);
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hyperbus_arbiter.md
HYPERBUS_ARBITER -- requirements
Module: hyperbus_arbiter

Interface
REQ-001 Parameter ADR_WIDTH, default 32: width of requester and core address buses.
REQ-002 Parameter DATA_WIDTH, default 16: width of requester and core data buses.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 p0_rrq / p1_rrq  input  1 each  level read request, held until that port's ack.
REQ-006 p0_wrq / p1_wrq  input  1 each  level write request, held until that port's ack.
REQ-007 p0_adr_i / p1_adr_i  input  ADR_WIDTH each  transaction address.
REQ-008 p0_dat_i / p1_dat_i  input  DATA_WIDTH each  write data.
REQ-009 p0_dat_o / p1_dat_o  output  DATA_WIDTH each  last read data returned to that port.
REQ-010 p0_ack / p1_ack  output  1 each  one-cycle completion pulse.
REQ-011 gnt  output  2  one-hot current owner; 2'b00 when idle.
REQ-012 hbus_adr_o  output  ADR_WIDTH  address to the hyperbus core.
REQ-013 hbus_dat_o  output  DATA_WIDTH  write data to the core.
REQ-014 hbus_dat_i  input  DATA_WIDTH  read data from the core.
REQ-015 hbus_rrq / hbus_wrq  output  1 each  one-cycle request pulses to the core.
REQ-016 hbus_ready  input  1  core idle, able to accept a request.
REQ-017 hbus_valid  input  1  core read data valid.
REQ-018 hbus_busy  input  1  core transaction in progress.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT; all outputs registered.
REQ-020 IDLE: when hbus_ready=1 and any port requests, select the winner; latch its address, write data and type into internal registers; set gnt; go to ISSUE in the next cycle.
REQ-021 IDLE with hbus_ready=0: no grant; pending requests wait.
REQ-022 Per-port type: rrq and wrq both high selects read; wrq is serviced in a later grant if still asserted after ack.
REQ-023 ISSUE: assert exactly one of hbus_rrq/hbus_wrq for exactly one cycle; clear the seen_busy flag; go to WAIT.
REQ-024 WAIT: set seen_busy on any cycle with hbus_busy=1.
REQ-025 WAIT read: on hbus_valid=1, capture hbus_dat_i into the owner's dat_o, pulse the owner's ack in the next cycle, clear gnt, go to IDLE.
REQ-026 WAIT write: on the first cycle with seen_busy=1 and hbus_busy=0, pulse the owner's ack in the next cycle, clear gnt, go to IDLE.
REQ-027 hbus_valid outside a granted read SHALL be ignored; dat_o is not updated.
REQ-028 hbus_adr_o/hbus_dat_o hold the latched values from ISSUE until the next grant.
REQ-029 Request withdrawn before grant: no effect. Request withdrawn after grant: transaction completes and ack still pulses.
REQ-030 Non-owner dat_o and ack are unaffected by the owner's transaction.
REQ-031 Earliest re-grant occurs in the cycle after ack; a requester sees ack before its request could be re-sampled.

Reset
REQ-032 While rstn=0: FSM=IDLE, gnt=0, hbus_rrq=hbus_wrq=0, acks=0, hbus_adr_o=0, hbus_dat_o=0, p*_dat_o=0, seen_busy=0, last-served pointer=port1.
REQ-033 Reset asserted mid-transaction SHALL abort it immediately with no ack.

Configuration
REQ-034 Macro HYPERBUS_ARB_RR_EN defined: round-robin arbitration; with both ports requesting, the port not served last wins; the pointer updates at each grant.
REQ-035 Macro HYPERBUS_ARB_RR_EN undefined: fixed priority; port 0 always wins; the pointer logic is absent.

Verification
REQ-036 p0 read at 0x00000010, core returns 0xBEEF -> hbus_rrq single pulse with hbus_adr_o=0x00000010; p0_dat_o=0xBEEF; one p0_ack; p1 outputs unchanged.
REQ-037 p1 write 0x1234 at 0x20: core busy 5 cycles -> hbus_wrq single pulse with hbus_dat_o=0x1234; p1_ack one cycle after busy falls; gnt returns to 00.
REQ-038 p0 and p1 request reads together for 4 back-to-back transactions -> RR_EN: grants 0,1,0,1; without RR_EN: all grants go to p0 while p0 holds its request.
REQ-039 p0 asserts rrq and wrq together -> read is issued first; after ack with wrq still high, write is issued next.
REQ-040 hbus_ready=0 while requests are pending -> no hbus_rrq/hbus_wrq and gnt=00 until hbus_ready=1.
REQ-041 rstn pulled low during WAIT -> gnt=00 and no ack; after release, pending request re-granted from IDLE.
